// File: rtl/out_fm_pkg.sv
// Shared definitions for the out_fm bank, load engine and store engine:
// FSM state type, bank read latency and the per-bank capacity helper.
package out_fm_pkg;

  // Cycles from bank_rd_ena to valid bank_rd_data.
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } st_state_e;

  // Words held by one bank: output channels split evenly over Y banks.
  function automatic int cap_words(input int tn, input int tr, input int tc, input int y);
    return (tn / y) * tr * tc;
  endfunction

endpackage

// File: rtl/out_fm_st_fifo.sv
// Synchronous skid FIFO for the store engine. Push and pop in the same
// cycle leave the occupancy unchanged. rd_data shows the head entry
// combinationally. The caller decides whether a push is allowed; a pop
// on an empty FIFO is ignored.
module out_fm_st_fifo #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [DW-1:0]                      wr_data,
  input  logic                               pop,
  output logic [DW-1:0]                      rd_data,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(FIFO_DEPTH));
  assign count    = r_count;
  assign rd_data  = r_mem[r_rd_ptr];
  assign w_do_pop = pop & ~empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)     r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/out_fm_st_engine.sv
// Store engine for one out_fm bank: drains CAP words through the bank's
// sequential read port and streams them out over valid/ready.
// Optional feature: define OUT_FM_ST_RELU_EN to zero negative words at the
// stream output (combinational, no added latency).
//
// Handshake: a word moves when m_valid & m_ready are both high on a rising
// edge; once m_valid is high, m_data/m_last stay stable until that happens.
// Reads are issued only while (reads in flight + FIFO occupancy) is below
// FIFO_DEPTH, so returning bank data always finds room in the FIFO.
module out_fm_st_engine
  import out_fm_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int Tn         = 16,
  parameter int Tr         = 64,
  parameter int Tc         = 16,
  parameter int Y          = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_fm_st_start,
  output logic          out_fm_st_done,
  output logic          st_busy,
  output logic          bank_rd_ena,
  input  logic [DW-1:0] bank_rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [1:0]    dbg_state
);

  localparam int            CAP    = cap_words(Tn, Tr, Tc, Y);
  localparam logic [AW-1:0] CAP_A  = AW'(CAP);
  localparam logic [AW-1:0] CAP_M1 = AW'(CAP - 1);
  localparam int            CW     = $clog2(FIFO_DEPTH + 1);

  st_state_e         r_state;
  logic [AW-1:0]     r_issued_cnt;
  logic [AW-1:0]     r_sent_cnt;
  logic [RD_LAT-1:0] r_rd_vld;

  logic [CW-1:0]     w_count;
  logic [CW:0]       w_outstanding;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DW-1:0]     w_head;
  logic [DW-1:0]     w_out_word;

  // Credits in use: reads still in the bank pipeline plus words parked in the FIFO.
  always_comb begin
    w_outstanding = (CW + 1)'(w_count);
    for (int i = 0; i < RD_LAT; i++) begin
      w_outstanding = w_outstanding + (CW + 1)'(r_rd_vld[i]);
    end
  end

  assign bank_rd_ena = (r_state == ISSUE) && (r_issued_cnt < CAP_A) &&
                       (w_outstanding < (CW + 1)'(FIFO_DEPTH));

  assign w_push   = r_rd_vld[RD_LAT-1] & (~w_full | w_pop);
  assign m_valid  = ~w_empty;
  assign w_pop    = m_valid & m_ready;
  assign m_last   = m_valid & (r_sent_cnt == CAP_M1);
  assign m_data   = m_valid ? w_out_word : '0;

  assign st_busy        = (r_state != IDLE);
  assign out_fm_st_done = (r_state == DONE);
  assign dbg_state      = r_state;

  // Output word shaping at the FIFO head.
  always_comb begin
`ifdef OUT_FM_ST_RELU_EN
    w_out_word = w_head[DW-1] ? '0 : w_head;
`else
    w_out_word = w_head;
`endif
  end

  // Read-valid pipeline mirroring the bank's read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld <= '0;
    end else begin
      r_rd_vld[0] <= bank_rd_ena;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
      end
    end
  end

  // Store sequencing: issue CAP reads, wait for the last word to leave, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_issued_cnt <= '0;
      r_sent_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_issued_cnt <= '0;
          r_sent_cnt   <= '0;
          if (out_fm_st_start) r_state <= ISSUE;
        end
        ISSUE: begin
          if (bank_rd_ena) begin
            r_issued_cnt <= r_issued_cnt + 1'b1;
            if (r_issued_cnt == CAP_M1) r_state <= DRAIN;
          end
          if (w_pop) r_sent_cnt <= r_sent_cnt + 1'b1;
        end
        DRAIN: begin
          if (w_pop) r_sent_cnt <= r_sent_cnt + 1'b1;
          if (w_pop && m_last) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  out_fm_st_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (bank_rd_data),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

endmodule
